// File: rtl/mips_cpu_pkg.sv
// Shared types for the multicycle MIPS core: memory arbiter FSM/port encodings
// plus the instruction opcode and funct field enumerations.
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_t;

    localparam logic [3:0] BYTEEN_WORD = 4'b1111;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0A,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        F_SLL  = 6'h00,
        F_SRL  = 6'h02,
        F_JR   = 6'h08,
        F_ADD  = 6'h20,
        F_ADDU = 6'h21,
        F_SUB  = 6'h22,
        F_SUBU = 6'h23,
        F_AND  = 6'h24,
        F_OR   = 6'h25,
        F_XOR  = 6'h26,
        F_NOR  = 6'h27,
        F_SLT  = 6'h2A
    } funct_t;

    // The bus is word-addressed in practice; byte lanes select within the word.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/mips_cpu_mem_arbiter_if.sv
// Avalon-style memory bus between the arbiter (master) and external memory (slave).
interface mips_cpu_mem_arbiter_if;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/mips_cpu_mem_arbiter.sv
// Shares one memory bus between instruction fetch and data load/store ports,
// one transaction at a time, round-robin on conflict, with a registered ack pulse.
module mips_cpu_mem_arbiter
    import mips_cpu_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_req,
    input  logic [31:0]                   i_addr,
    output logic [31:0]                   i_rdata,
    output logic                          i_ack,
    input  logic                          d_req,
    input  logic                          d_write,
    input  logic [31:0]                   d_addr,
    input  logic [31:0]                   d_wdata,
    input  logic [3:0]                    d_byteen,
    output logic [31:0]                   d_rdata,
    output logic                          d_ack,
    mips_cpu_mem_arbiter_if.master        avm,
    output logic                          busy
);

    arb_state_t  state_q, state_d;
    arb_port_t   owner_q, owner_d;
    arb_port_t   last_q, last_d;
    arb_port_t   grant_s;
    logic [31:0] addr_q, addr_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        busy_q, busy_d;

    // Next-state, command latch, read capture and ack generation.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        addr_d    = addr_q;
        read_d    = read_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;

        // D wins when it is alone or when I was served last.
        grant_s = (d_req && (!i_req || last_q == PORT_I)) ? PORT_D : PORT_I;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    owner_d = grant_s;
                    state_d = BUS;
                    if (grant_s == PORT_D) begin
                        addr_d  = word_align(d_addr);
                        read_d  = !d_write;
                        write_d = d_write;
                        wdata_d = d_wdata;
                        be_d    = d_byteen;
                    end else begin
                        addr_d  = word_align(i_addr);
                        read_d  = 1'b1;
                        write_d = 1'b0;
                        be_d    = BYTEEN_WORD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUS: begin
                if (!avm.avm_waitrequest) begin
                    if (read_q && owner_q == PORT_I) begin
                        i_rdata_d = avm.avm_readdata;
                    end else if (read_q) begin
                        d_rdata_d = avm.avm_readdata;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    last_d  = owner_q;
                    state_d = RESP;
                    if (owner_q == PORT_I) begin
                        i_ack_d = 1'b1;
                    end else begin
                        d_ack_d = 1'b1;
                    end
                end else begin
                    state_d = BUS;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset clears the bus command immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= PORT_I;
            last_q    <= PORT_I;
            addr_q    <= 32'h0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            wdata_q   <= 32'h0;
            be_q      <= 4'h0;
            i_rdata_q <= 32'h0;
            d_rdata_q <= 32'h0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            read_q    <= read_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            busy_q    <= busy_d;
        end
    end

    assign avm.avm_address    = addr_q;
    assign avm.avm_read       = read_q;
    assign avm.avm_write      = write_q;
    assign avm.avm_writedata  = wdata_q;
    assign avm.avm_byteenable = be_q;
    assign i_rdata            = i_rdata_q;
    assign d_rdata            = d_rdata_q;
    assign i_ack              = i_ack_q;
    assign d_ack              = d_ack_q;
    assign busy               = busy_q;

endmodule

// File: doc/mips_cpu_mem_arbiter.md
# mips_cpu_mem_arbiter

Shares one Avalon-style memory bus (single `waitrequest`, read data valid when `waitrequest` is low) between the CPU's instruction-fetch port and data load/store port. It sits between the multicycle core's fetch/memory stages and external memory, and it is the only bus master. The block latches one request at a time and grants round-robin on conflict. It holds the bus command stable until the slave accepts it, then returns a registered one-cycle acknowledge to the owner.

## Interface
Parameters: none; widths are fixed at 32-bit address/data and 4-bit byte enable.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, synchronous, active-high.
- i_req  in  1  instruction fetch request, level.
- i_addr  in  32  fetch byte address.
- i_rdata  out  32  fetched word; registered and valid while i_ack=1.
- i_ack  out  1  one-cycle completion pulse for the fetch port.
- d_req  in  1  data request, level.
- d_write  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_byteen  in  4  store/load byte lanes.
- d_rdata  out  32  load word; valid while d_ack=1.
- d_ack  out  1  one-cycle completion pulse for the data port.
- avm_address  out  32  bus address, word-aligned.
- avm_read  out  1  bus read command.
- avm_write  out  1  bus write command.
- avm_writedata  out  32  bus write data.
- avm_byteenable  out  4  bus byte lanes.
- avm_readdata  in  32  bus read data.
- avm_waitrequest  in  1  slave stall.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- FSM has three states: IDLE, BUS, RESP. A `owner` register records I or D. A `last` register records the last granted port.
- **IDLE:** samples i_req/d_req.
  - Only one request high: grant it.
  - Both high: grant the port that is not `last`.
  - On grant, register the command into the bus outputs and go to BUS:
    - address = addr with [1:0] forced to 00.
    - Fetch: avm_read=1, byteenable=4'b1111.
    - Data: read = !d_write, write = d_write, writedata = d_wdata, byteenable = d_byteen.
- **BUS:** all avm_* outputs are held unchanged while avm_waitrequest=1.
  - In the first cycle with avm_waitrequest=0:
    - For a read, capture avm_readdata into the owner's rdata register.
    - Clear avm_read/avm_write, update `last` to `owner`, go to RESP.
- **RESP:** the owner's ack=1 for exactly this cycle; then go to IDLE.
  - Writes pulse d_ack and leave d_rdata unchanged.
- Request sampling happens only in IDLE. A requester must deassert req, or present a new transaction, by the cycle after its ack. A req still high in IDLE is treated as a new transaction.
- Requesters hold addr/wdata/byteen stable from req rise until ack.
- The non-owner's req is ignored while it is not IDLE; it stays pending and is not lost.
- avm_read and avm_write are never high together. i_ack and d_ack are never high together.

## Timing
- **Reset values:**
  - All avm_* outputs = 0; i_ack = d_ack = 0; i_rdata = d_rdata = 0; busy = 0.
  - state = IDLE; owner = I; last = I, so the first conflict goes to D.
- **Latency:**
  - req high in IDLE at cycle 0 → bus command visible at cycle 1.
  - With waitrequest=0 at cycle 1, ack is at cycle 2.
  - Each waitrequest=1 cycle adds one cycle of latency.
- **Throughput:** at most one transaction per 3 cycles.
- **rst mid-transaction:** the bus command drops at the next edge and no ack is issued. The aborted owner must re-request.
- **waitrequest=0 in the very first BUS cycle:** completes immediately.
- **Both requests rising together right after reset:** D is served first, then I.

## Structure
- Package `mips_cpu_pkg` holds:
  - `arb_state_t` (IDLE, BUS, RESP);
  - `arb_port_t` (PORT_I, PORT_D);
  - constant BYTEEN_WORD = 4'b1111.
- The core's opcode and funct enums move into the same package.
- No sub-module: the two-way round-robin pick is one expression inline.

## Test plan
- **Single fetch:** i_req=1, i_addr=32'h0000_0104, slave returns 32'h2402_0005 with 0 wait.
  - Expect avm_address=32'h104 and avm_read=1 at cycle 1.
  - Expect i_ack=1 with i_rdata=32'h2402_0005 at cycle 2.
- **Store with stalls:** d_req=1, d_write=1, d_addr=32'h1003, d_wdata=32'hDEAD_BEEF, d_byteen=4'b0011, waitrequest=1 for 3 cycles.
  - Expect address=32'h1000 and the command held for 4 cycles.
  - Expect d_ack exactly once; d_rdata unchanged.
- **Conflict after reset:** i_req=d_req=1 together.
  - Expect D granted first.
  - Then I granted in the IDLE following D's RESP, with no duplicate D transaction.
- **Round-robin:** both requests held high continuously.
  - Grants alternate D, I, D, I with ack spacing of 3 cycles.
- **Reset abort:** rst=1 during BUS with waitrequest=1.
  - Next cycle: all avm_* = 0, busy = 0, no ack.
- **Continuous requests:** req held high across ack.
  - Expect a second bus transaction starting the cycle after RESP, and exactly one ack per transaction.
